// File: rtl/b11_sched_pkg.sv
// Shared types and defaults for the b11 scrambler-engine scheduler.
package b11_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int B11_N_REQ_DEF   = 4;
  localparam int B11_DATA_W_DEF  = 6;
  localparam int B11_TIMEOUT_DEF = 63;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module rr_pick
  import b11_sched_pkg::*;
#(
  parameter int N_REQ = B11_N_REQ_DEF,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    s = (s >= N_REQ) ? (s - N_REQ) : s;
    return IDX_W'(s);
  endfunction

  // Scan requesters in rotated order and keep only the first hit.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s          = rot_idx(ptr_i, k);
      hit_s           = req_i[cand_s] & ~any_o;
      grant_o[cand_s] = grant_o[cand_s] | hit_s;
      idx_o           = hit_s ? cand_s : idx_o;
      any_o           = any_o | hit_s;
    end
  end

endmodule

// File: rtl/b11_scheduler.sv
// Round-robin job scheduler sharing one b11 scrambler engine among N_REQ requesters.
// Optional engine watchdog enabled by defining B11_SCHED_WATCHDOG_EN.
module b11_scheduler
  import b11_sched_pkg::*;
#(
  parameter int N_REQ   = B11_N_REQ_DEF,
  parameter int DATA_W  = B11_DATA_W_DEF,
  parameter int TIMEOUT = B11_TIMEOUT_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_din,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_dout,
  output logic                      busy,
  output logic [idx_w(N_REQ)-1:0]   grant_id
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [DATA_W-1:0] oper_q, oper_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [N_REQ-1:0] pick_oh_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             rsp_hs_s;

`ifdef B11_SCHED_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .grant_o (pick_oh_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  assign rsp_hs_s = rsp_ready[grant_q];

  // Next-state and datapath latch decisions.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    oper_d   = oper_q;
    result_d = result_q;
`ifdef B11_SCHED_WATCHDOG_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d = ST_ISSUE;
          grant_d = pick_idx_s;
          oper_d  = req_data[int'(pick_idx_s)*DATA_W +: DATA_W];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef B11_SCHED_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (eng_done) begin
          state_d  = ST_RESP;
          result_d = eng_dout;
`ifdef B11_SCHED_WATCHDOG_EN
          err_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Engine never answered: abort with an error response.
          state_d  = ST_RESP;
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          state_d  = ST_WAIT;
          cnt_d    = cnt_q + CNT_W'(1);
`else
        end else begin
          state_d  = ST_WAIT;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_hs_s) begin
          state_d = ST_IDLE;
          rr_d    = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : (grant_q + IDX_W'(1));
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      oper_q   <= '0;
      result_q <= '0;
`ifdef B11_SCHED_WATCHDOG_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      oper_q   <= oper_d;
      result_q <= result_d;
`ifdef B11_SCHED_WATCHDOG_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs decode from state; everything idles at zero outside its phase.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    eng_start = 1'b0;
    eng_din   = '0;
    busy      = (state_q != ST_IDLE);
    grant_id  = grant_q;
    case (state_q)
      ST_IDLE: begin
        req_ready = reset ? pick_oh_s : '0;
        grant_id  = reset ? pick_idx_s : '0;
      end
      ST_ISSUE: begin
        eng_start = 1'b1;
        eng_din   = oper_q;
      end
      ST_WAIT: begin
        eng_din   = oper_q;
      end
      ST_RESP: begin
        rsp_valid = ONE_HOT0 << grant_q;
        rsp_data  = result_q;
`ifdef B11_SCHED_WATCHDOG_EN
        rsp_err   = err_q;
`else
        rsp_err   = 1'b0;
`endif
      end
      default: begin
        busy      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_b11_scheduler.sv
// Self-checking bench for b11_scheduler; the bench acts as the engine and the requesters.
module tb_b11_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [23:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [5:0]  rsp_data;
  logic        rsp_err;
  logic [3:0]  rsp_ready;
  logic        eng_start;
  logic [5:0]  eng_din;
  logic        eng_done;
  logic [5:0]  eng_dout;
  logic        busy;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_m     = 0;

  always #5 clock = ~clock;

  b11_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .eng_start (eng_start),
    .eng_din   (eng_din),
    .eng_done  (eng_done),
    .eng_dout  (eng_dout),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference arbitration: lowest index at/after the pointer, wrapping.
  function automatic int pick_m(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh_m(input int w);
    logic [3:0] r;
    r = 4'b0000;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // Runs one job from an IDLE cycle (called just after a falling edge).
  task automatic run_job(input logic [3:0] vmask, input logic [23:0] data, input int lat,
                         input int bp, input logic [5:0] dout, input bit hold_valid);
    int w;
    logic [3:0] oh;
    logic [5:0] opnd;
    w    = pick_m(vmask, rr_m);
    oh   = oh_m(w);
    opnd = data[w*6 +: 6];
    req_valid = vmask;
    req_data  = data;
    rsp_ready = 4'b0000;
    eng_done  = 1'b0;
    #1;
    check_eq("idle_busy", busy, 0);
    check_eq("accept_ready", req_ready, oh);
    check_eq("accept_grant", grant_id, w);
    @(negedge clock);
    check_eq("issue_start", eng_start, 1);
    check_eq("issue_din", eng_din, opnd);
    check_eq("issue_grant", grant_id, w);
    check_eq("issue_ready", req_ready, 0);
    if (!hold_valid) begin
      req_valid = 4'($urandom);
      req_data  = 24'($urandom);
    end
    eng_done = 1'($urandom);
    eng_dout = 6'($urandom);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clock);
      check_eq("wait_start", eng_start, 0);
      check_eq("wait_din", eng_din, opnd);
      check_eq("wait_valid", rsp_valid, 0);
      check_eq("wait_busy", busy, 1);
      eng_done = (k == lat);
      eng_dout = (k == lat) ? dout : 6'($urandom);
    end
    @(negedge clock);
    check_eq("rsp_valid", rsp_valid, oh);
    check_eq("rsp_data", rsp_data, dout);
    check_eq("rsp_err", rsp_err, 0);
    check_eq("rsp_grant", grant_id, w);
    eng_done = 1'($urandom);
    eng_dout = 6'($urandom);
    for (int b = 0; b < bp; b++) begin
      rsp_ready = 4'($urandom) & ~oh;
      if (!hold_valid) req_valid = 4'($urandom);
      #1;
      check_eq("bp_ready", req_ready, 0);
      @(negedge clock);
      check_eq("bp_valid", rsp_valid, oh);
      check_eq("bp_data", rsp_data, dout);
    end
    rsp_ready = 4'($urandom) | oh;
    #1;
    check_eq("hs_ready", req_ready, 0);
    @(negedge clock);
    eng_done  = 1'b0;
    rsp_ready = 4'b0000;
    rr_m = (w + 1) % 4;
    check_eq("post_busy", busy, 0);
    check_eq("post_valid", rsp_valid, 0);
    check_eq("post_din", eng_din, 0);
    check_eq("post_ready", req_ready, oh_m(pick_m(req_valid, rr_m)));
  endtask

  logic [3:0] fair_seq [5];
  int         waits;
  int         w_wd;
  logic [3:0] vm;

  initial begin
    fair_seq[0] = 4'b0001; fair_seq[1] = 4'b0010; fair_seq[2] = 4'b0100;
    fair_seq[3] = 4'b1000; fair_seq[4] = 4'b0001;
    reset = 1'b0; req_valid = 4'b0000; req_data = 24'h0; rsp_ready = 4'b0000;
    eng_done = 1'b0; eng_dout = 6'h00;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", eng_start, 0);
    check_eq("rst_valid", rsp_valid, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_grant", grant_id, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    rr_m  = 0;

    // Fairness with all four requesting continuously.
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'hF;
      #1;
      check_eq("fair_order", req_ready, fair_seq[i]);
      run_job(4'hF, 24'($urandom), int'($urandom_range(0, 2)), 0, 6'($urandom), 1'b1);
    end

    // Single request, engine answers in the first WAIT cycle.
    run_job(4'b0010, {6'h00, 6'h00, 6'h15, 6'h00}, 0, 0, 6'h2A, 1'b0);
    // Back-pressure for five cycles.
    run_job(4'b0110, 24'($urandom), 1, 5, 6'($urandom), 1'b0);

    for (int i = 0; i < 30; i++) begin
      vm = 4'($urandom_range(1, 15));
      run_job(vm, 24'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              6'($urandom), 1'b0);
    end

    // Reset while the job sits in WAIT.
    req_valid = 4'b0100; req_data = 24'($urandom); rsp_ready = 4'b0000; eng_done = 1'b0;
    @(negedge clock);
    req_valid = 4'b0000;
    @(negedge clock);
    check_eq("prerst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_din", eng_din, 0);
    check_eq("midrst_start", eng_start, 0);
    check_eq("midrst_valid", rsp_valid, 0);
    check_eq("midrst_data", rsp_data, 0);
    check_eq("midrst_err", rsp_err, 0);
    check_eq("midrst_grant", grant_id, 0);
    rr_m = 0;
    @(negedge clock);
    check_eq("midrst_hold", busy, 0);
    reset = 1'b1;
    req_valid = 4'b1001;
    #1;
    check_eq("postrst_first", req_ready, 4'b0001);
    run_job(4'b1001, 24'($urandom), 0, 0, 6'($urandom), 1'b0);

    // Engine never answers.
    w_wd = pick_m(4'b1000, rr_m);
    req_valid = 4'b1000; req_data = 24'($urandom); rsp_ready = 4'b0000; eng_done = 1'b0;
    @(negedge clock);
    req_valid = 4'b0000;
    waits = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (rsp_valid != 4'b0000) break;
      waits++;
    end
`ifdef B11_SCHED_WATCHDOG_EN
    check_eq("wd_cycles", waits, 63);
    check_eq("wd_valid", rsp_valid, oh_m(w_wd));
    check_eq("wd_data", rsp_data, 0);
    check_eq("wd_err", rsp_err, 1);
    rsp_ready = oh_m(w_wd);
    @(negedge clock);
    rsp_ready = 4'b0000;
    rr_m = (w_wd + 1) % 4;
    check_eq("wd_idle", busy, 0);
`else
    check_eq("nowd_waits", waits, 200);
    check_eq("nowd_busy", busy, 1);
    check_eq("nowd_err", rsp_err, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rr_m = 0;
`endif
    run_job(4'($urandom_range(1, 15)), 24'($urandom), 1, 1, 6'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
